fifo_tx_scheduler: RTL and testbench
====================================

Name: fifo_tx_scheduler

Overview:
- Sequences draining of synq_fifo into uart_tx. Replaces the free-running read strobe between FIFO and transmitter.
- Pops one byte at a time, only when the transmitter is idle. Honours the FIFO's 1-cycle read latency and waits for Tx_Done before the next pop.
- Batches traffic: a burst starts when occupancy reaches a threshold, or when an idle timeout after the last write expires.
- Sits between control_logic/synq_fifo and uart_tx in top.

Parameters:
- DEPTH, 16, FIFO depth in bytes; must match synq_fifo.
- THRESHOLD, 4, occupancy that starts a burst; range 1..DEPTH.
- TIMEOUT_CYCLES, 10000, cycles after the last write before a partial flush; 0 disables the timeout.
- GAP_CYCLES, 0, idle clocks inserted between Tx_Done and the next pop.

Ports:
- i_Clock  in  1  system clock
- i_Reset  in  1  synchronous, active-high reset
- i_Enable  in  1  when low, no new burst and no new pop; the current byte completes
- i_FIFO_Wr  in  1  copy of FIFO wr_en; used for occupancy tracking
- i_FIFO_Empty  in  1  FIFO f_empty
- i_FIFO_Full  in  1  FIFO f_full
- i_FIFO_Data  in  8  FIFO rd_data; valid 1 cycle after o_FIFO_Rd
- o_FIFO_Rd  out  1  FIFO rd_en; single-cycle pulse
- i_Tx_Active  in  1  uart_tx o_Tx_Active
- i_Tx_Done  in  1  uart_tx o_Tx_Done
- o_Tx_DV  out  1  uart_tx i_Tx_DV; single-cycle pulse
- o_Tx_Byte  out  8  uart_tx i_Tx_Byte
- o_Busy  out  1  high in any state other than IDLE
- o_Count  out  $clog2(DEPTH+1)  tracked occupancy
- o_Flush  out  1  1-cycle pulse when a burst is started by timeout

Behaviour:
- Reset (i_Reset=1 at an i_Clock edge):
  - State goes to IDLE; count, timer and gap counter clear to 0.
  - All outputs are 0.
  - Reset overrides every other input, including mid-burst.
  - After reset, no o_Tx_DV is issued until i_Tx_Active=0.
- Occupancy count:
  - +1 on (i_FIFO_Wr & !i_FIFO_Full); -1 on o_FIFO_Rd.
  - Both in the same cycle: count unchanged.
  - Count saturates at DEPTH and at 0.
- Timer:
  - Cleared on any accepted write and whenever count=0.
  - Otherwise increments in IDLE, saturating at TIMEOUT_CYCLES.
- States:
  - IDLE: go to POP if i_Enable & !i_FIFO_Empty & !i_Tx_Active & (count>=THRESHOLD | timer==TIMEOUT_CYCLES with TIMEOUT_CYCLES!=0). o_Flush pulses for 1 cycle if only the timeout condition is true.
  - POP: o_FIFO_Rd=1 for exactly this cycle; always go to LOAD.
  - LOAD: capture i_FIFO_Data into the o_Tx_Byte register; go to SEND.
  - SEND: o_Tx_DV=1 for exactly this cycle, with o_Tx_Byte stable; go to WAIT_DONE.
  - WAIT_DONE: on i_Tx_Done go to GAP, or to NEXT directly if GAP_CYCLES=0.
  - GAP: count GAP_CYCLES clocks, then go to NEXT.
  - NEXT (1 cycle): go to POP if i_Enable & !i_FIFO_Empty & !i_Tx_Active, else go to IDLE. A burst therefore drains to empty regardless of THRESHOLD.
- Latency:
  - Trigger true in IDLE at cycle N: o_FIFO_Rd at N+1, o_Tx_DV at N+3.
  - i_Tx_Done at cycle M with GAP=0: next o_FIFO_Rd at M+2.
- o_FIFO_Rd is never asserted while i_FIFO_Empty=1. i_FIFO_Empty is authoritative for pops; count is used only for the threshold decision.
- A write during a burst is included in the same burst.
- i_Enable falling mid-burst: the byte in POP/LOAD/SEND/WAIT_DONE completes, then the block returns to IDLE.
- o_Tx_Byte holds its value until the next LOAD.

Decomposition:
- Shared header uart_fifo_defs.vh holds:
  - state encodings (IDLE, POP, LOAD, SEND, WAIT_DONE, GAP, NEXT; 3-bit)
  - byte width 8
  - the count-width function
- One sub-module, sched_idle_timer: saturating timeout counter with clear/enable, ports i_Clock, i_Reset, i_Clear, i_En, o_Expired.
- Occupancy counter and FSM stay in fifo_tx_scheduler.

Test Plan:
- Write 0x11,0x22,0x33 with THRESHOLD=4, TIMEOUT=0 → no o_FIFO_Rd. A 4th write of 0x44 → four o_Tx_DV pulses with bytes 0x11,0x22,0x33,0x44 in order, o_Count returns to 0, o_Busy falls after the last Tx_Done.
- TIMEOUT_CYCLES=50: write 0xA5 only → o_Flush and o_FIFO_Rd exactly 51 cycles after the write; o_Tx_DV 2 cycles later with o_Tx_Byte=0xA5.
- i_Tx_Active held high when the trigger occurs → no o_FIFO_Rd until Active drops. Then o_Tx_DV 3 cycles after the drop, and exactly one DV per Tx_Done.
- Simultaneous i_FIFO_Wr and o_FIFO_Rd at count=5 → o_Count stays 5. Fill to DEPTH=16 plus an extra write while i_FIFO_Full=1 → o_Count stays 16.
- i_Reset asserted in WAIT_DONE → next cycle o_Busy=0, o_Count=0, o_FIFO_Rd=0, o_Tx_DV=0. No DV while i_Tx_Active=1.
- GAP_CYCLES=3, i_Enable dropped during the 2nd byte of a 5-byte burst → 2nd byte completes. Spacing from Tx_Done to the next o_FIFO_Rd is 5 cycles for bytes already in the burst. The block goes IDLE with o_Count=3.

Source files
------------

// File: rtl/fifo_tx_scheduler_pkg.sv
// rtl/fifo_tx_scheduler_pkg.sv - shared state encodings, byte width and count-width helper
package fifo_tx_scheduler_pkg;

  localparam int BYTE_W = 8;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_POP       = 3'd1;
  localparam logic [2:0] ST_LOAD      = 3'd2;
  localparam logic [2:0] ST_SEND      = 3'd3;
  localparam logic [2:0] ST_WAIT_DONE = 3'd4;
  localparam logic [2:0] ST_GAP       = 3'd5;
  localparam logic [2:0] ST_NEXT      = 3'd6;

  typedef logic [BYTE_W-1:0] tx_byte_t;

  function automatic int count_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sched_idle_timer.sv
// rtl/sched_idle_timer.sv - saturating idle counter; expires at TIMEOUT_CYCLES, never when 0
module sched_idle_timer #(
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_Clear,
  input  logic i_En,
  output logic o_Expired
);

  localparam int TW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CYCLES);

  logic [TW-1:0] timer_q;
  logic [TW-1:0] timer_d;

  always_comb begin
    timer_d = timer_q;
    if (i_Clear) begin
      timer_d = '0;
    end else if (i_En && (timer_q != LIMIT)) begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  assign o_Expired = (TIMEOUT_CYCLES != 0) && (timer_q == LIMIT);

endmodule

// File: rtl/fifo_tx_scheduler.sv
// rtl/fifo_tx_scheduler.sv - drains synq_fifo into uart_tx one byte at a time in bursts
module fifo_tx_scheduler
  import fifo_tx_scheduler_pkg::*;
#(
  parameter int DEPTH          = 16,
  parameter int THRESHOLD      = 4,
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int GAP_CYCLES     = 0
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset,
  input  logic                          i_Enable,
  input  logic                          i_FIFO_Wr,
  input  logic                          i_FIFO_Empty,
  input  logic                          i_FIFO_Full,
  input  logic [BYTE_W-1:0]             i_FIFO_Data,
  output logic                          o_FIFO_Rd,
  input  logic                          i_Tx_Active,
  input  logic                          i_Tx_Done,
  output logic                          o_Tx_DV,
  output logic [BYTE_W-1:0]             o_Tx_Byte,
  output logic                          o_Busy,
  output logic [count_width(DEPTH)-1:0] o_Count,
  output logic                          o_Flush
);

  localparam int CW = count_width(DEPTH);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] THR_C    = CW'(THRESHOLD);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [GW-1:0] gap_q, gap_d;
  tx_byte_t      byte_q, byte_d;
  logic          flush_q, flush_d;

  logic wr_accept;
  logic pop;
  logic can_pop;
  logic thr_hit;
  logic timer_hit;

  assign wr_accept = i_FIFO_Wr & ~i_FIFO_Full;
  assign pop       = (state_q == ST_POP);
  // FIFO emptiness gates every pop; the tracked count only decides when a burst may start.
  assign can_pop   = i_Enable & ~i_FIFO_Empty & ~i_Tx_Active;
  assign thr_hit   = (count_q >= THR_C);

  sched_idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .i_Clock  (i_Clock),
    .i_Reset  (i_Reset),
    .i_Clear  (wr_accept | (count_q == '0)),
    .i_En     (state_q == ST_IDLE),
    .o_Expired(timer_hit)
  );

  always_comb begin
    count_d = count_q;
    if (wr_accept && !pop) begin
      if (count_q != DEPTH_C) count_d = count_q + 1'b1;
    end else if (pop && !wr_accept) begin
      if (count_q != '0) count_d = count_q - 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    byte_d  = byte_q;
    flush_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (can_pop && (thr_hit || timer_hit)) begin
          state_d = ST_POP;
          flush_d = ~thr_hit;
        end
      end
      ST_POP:  state_d = ST_LOAD;
      ST_LOAD: begin
        byte_d  = i_FIFO_Data;
        state_d = ST_SEND;
      end
      ST_SEND: state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (i_Tx_Done) begin
          gap_d   = '0;
          state_d = (GAP_CYCLES == 0) ? ST_NEXT : ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = ST_NEXT;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      // Bursts keep going until empty; threshold is only re-checked from IDLE.
      ST_NEXT: state_d = can_pop ? ST_POP : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      gap_q   <= '0;
      byte_q  <= '0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      gap_q   <= gap_d;
      byte_q  <= byte_d;
      flush_q <= flush_d;
    end
  end

  assign o_FIFO_Rd = pop;
  assign o_Tx_DV   = (state_q == ST_SEND);
  assign o_Tx_Byte = byte_q;
  assign o_Busy    = (state_q != ST_IDLE);
  assign o_Count   = count_q;
  assign o_Flush   = flush_q;

endmodule

// File: tb/tb_fifo_tx_scheduler.sv
// tb/tb_fifo_tx_scheduler.sv - scoreboard bench: dut0 timeout=50 gap=0, dut1 timeout=0 gap=3
module tb_fifo_tx_scheduler;

  localparam int TX_LEN = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests_run = 0;
  int tests_failed = 0;

  logic       en        [2];
  logic       wr        [2];
  logic [7:0] wdata     [2];
  logic       fempty    [2];
  logic       ffull     [2];
  logic [7:0] frdata    [2];
  logic       rd        [2];
  logic       act_force [2];
  logic       tx_active [2];
  logic       tx_done   [2];
  logic       dv        [2];
  logic [7:0] txbyte    [2];
  logic       busy      [2];
  logic [4:0] cnt       [2];
  logic       flush     [2];
  int         tx_cnt    [2];

  logic [7:0] fq   [2][$];
  logic [7:0] expq [2][$];
  int rd_cnt [2];
  int dv_cnt [2];
  int done_cnt [2];
  int flush_cnt [2];
  int last_rd [2];
  int last_done [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    fifo_tx_scheduler #(
      .DEPTH(16),
      .THRESHOLD(4),
      .TIMEOUT_CYCLES(g == 0 ? 50 : 0),
      .GAP_CYCLES(g == 0 ? 0 : 3)
    ) u_dut (
      .i_Clock     (clk),
      .i_Reset     (rst),
      .i_Enable    (en[g]),
      .i_FIFO_Wr   (wr[g]),
      .i_FIFO_Empty(fempty[g]),
      .i_FIFO_Full (ffull[g]),
      .i_FIFO_Data (frdata[g]),
      .o_FIFO_Rd   (rd[g]),
      .i_Tx_Active (tx_active[g]),
      .i_Tx_Done   (tx_done[g]),
      .o_Tx_DV     (dv[g]),
      .o_Tx_Byte   (txbyte[g]),
      .o_Busy      (busy[g]),
      .o_Count     (cnt[g]),
      .o_Flush     (flush[g])
    );
    assign tx_active[g] = (tx_cnt[g] != 0) || act_force[g];
  end

  // FIFO with registered read data, and a uart_tx stand-in busy for TX_LEN cycles.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        fq[i].delete();
        frdata[i]  <= 8'h00;
        fempty[i]  <= 1'b1;
        ffull[i]   <= 1'b0;
        tx_cnt[i]  <= 0;
        tx_done[i] <= 1'b0;
      end else begin
        if (rd[i] && fq[i].size() > 0) frdata[i] <= fq[i].pop_front();
        if (wr[i] && !ffull[i]) fq[i].push_back(wdata[i]);
        fempty[i]  <= (fq[i].size() == 0);
        ffull[i]   <= (fq[i].size() >= 16);
        tx_done[i] <= 1'b0;
        if (dv[i]) begin
          tx_cnt[i] <= TX_LEN;
        end else if (tx_cnt[i] == 1) begin
          tx_cnt[i]  <= 0;
          tx_done[i] <= 1'b1;
        end else if (tx_cnt[i] > 1) begin
          tx_cnt[i] <= tx_cnt[i] - 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [7:0] exp_b;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        expq[i].delete();
        rd_cnt[i] = 0; dv_cnt[i] = 0; done_cnt[i] = 0; flush_cnt[i] = 0;
        last_rd[i] = -1; last_done[i] = -1;
      end else begin
        if (wr[i] && !ffull[i]) expq[i].push_back(wdata[i]);
        if (rd[i]) begin
          rd_cnt[i]++;
          last_rd[i] = cyc;
          tests_run++;
          if (fempty[i] !== 1'b0) begin
            tests_failed++;
            $display("FAIL pop_while_empty dut%0d: i_FIFO_Empty=%b during o_FIFO_Rd, required 0", i, fempty[i]);
          end
        end
        if (dv[i]) begin
          dv_cnt[i]++;
          tests_run++;
          if (expq[i].size() == 0) begin
            tests_failed++;
            $display("FAIL unexpected_dv dut%0d: o_Tx_Byte=%h with no byte outstanding", i, txbyte[i]);
          end else begin
            exp_b = expq[i].pop_front();
            if (txbyte[i] !== exp_b) begin
              tests_failed++;
              $display("FAIL tx_byte dut%0d: got %h, required %h", i, txbyte[i], exp_b);
            end
          end
        end
        if (flush[i]) flush_cnt[i]++;
        if (tx_done[i]) begin
          done_cnt[i]++;
          last_done[i] = cyc;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input int i, input logic [7:0] d);
    wr[i] = 1'b1;
    wdata[i] = d;
    tick(1);
    wr[i] = 1'b0;
  endtask

  // kind: 0 rd, 1 dv, 2 tx_done, 3 flush, other busy low; at = -1 when the bound expires
  task automatic wait_ev(input int i, input int kind, input int bound, output int at);
    logic hit;
    at = -1;
    for (int n = 0; n < bound; n++) begin
      @(negedge clk);
      case (kind)
        0:       hit = rd[i];
        1:       hit = dv[i];
        2:       hit = tx_done[i];
        3:       hit = flush[i];
        default: hit = ~busy[i];
      endcase
      if (hit === 1'b1) begin
        at = cyc;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    for (int i = 0; i < 2; i++) begin
      tests_run++;
      if ({busy[i], rd[i], dv[i], flush[i]} !== 4'b0000) begin
        tests_failed++;
        $display("FAIL reset_ctrl dut%0d: busy/rd/dv/flush=%b, required 0000", i, {busy[i], rd[i], dv[i], flush[i]});
      end
      tests_run++;
      if ({cnt[i], txbyte[i]} !== 13'd0) begin
        tests_failed++;
        $display("FAIL reset_data dut%0d: count=%0d byte=%h, required 0 and 00", i, cnt[i], txbyte[i]);
      end
    end
    rst = 1'b0;
    en[0] = 1'b1;
    en[1] = 1'b1;
    tick(2);
  endtask

  task automatic test_threshold_burst();
    int kw, at;
    do_reset();
    write_byte(0, 8'h11);
    write_byte(0, 8'h22);
    write_byte(0, 8'h33);
    tick(20);
    tests_run++;
    if (rd_cnt[0] !== 0) begin
      tests_failed++;
      $display("FAIL below_threshold_pop: got %0d pops, required 0", rd_cnt[0]);
    end
    tests_run++;
    if (cnt[0] !== 5'd3) begin
      tests_failed++;
      $display("FAIL count_three: got %0d, required 3", cnt[0]);
    end
    write_byte(0, 8'h44);
    kw = cyc;
    wait_ev(0, 0, 10, at);
    tests_run++;
    if (at !== kw + 1) begin
      tests_failed++;
      $display("FAIL pop_latency: got cycle %0d, required %0d", at, kw + 1);
    end
    wait_ev(0, 1, 10, at);
    tests_run++;
    if (at !== kw + 3) begin
      tests_failed++;
      $display("FAIL dv_latency: got cycle %0d, required %0d", at, kw + 3);
    end
    wait_ev(0, 4, 200, at);
    tests_run++;
    if (at < 0 || at !== last_done[0] + 2) begin
      tests_failed++;
      $display("FAIL busy_fall: got cycle %0d, required %0d", at, last_done[0] + 2);
    end
    tests_run++;
    if (dv_cnt[0] !== 4 || cnt[0] !== 5'd0 || expq[0].size() !== 0) begin
      tests_failed++;
      $display("FAIL burst_drain: dv=%0d count=%0d left=%0d, required 4 0 0", dv_cnt[0], cnt[0], expq[0].size());
    end
    tests_run++;
    if (flush_cnt[0] !== 0) begin
      tests_failed++;
      $display("FAIL threshold_flush: got %0d flush pulses, required 0", flush_cnt[0]);
    end
  endtask

  task automatic test_timeout_flush();
    int kw, at;
    do_reset();
    write_byte(0, 8'hA5);
    kw = cyc;
    wait_ev(0, 3, 80, at);
    tests_run++;
    if (at !== kw + 51) begin
      tests_failed++;
      $display("FAIL flush_latency: got cycle %0d, required %0d", at, kw + 51);
    end
    tests_run++;
    if (last_rd[0] !== kw + 51) begin
      tests_failed++;
      $display("FAIL flush_pop: got cycle %0d, required %0d", last_rd[0], kw + 51);
    end
    wait_ev(0, 1, 10, at);
    tests_run++;
    if (at !== kw + 53) begin
      tests_failed++;
      $display("FAIL flush_dv: got cycle %0d, required %0d", at, kw + 53);
    end
    wait_ev(0, 4, 50, at);
    tests_run++;
    if (at < 0 || flush_cnt[0] !== 1 || cnt[0] !== 5'd0) begin
      tests_failed++;
      $display("FAIL flush_end: idle_at=%0d flushes=%0d count=%0d, required >=0 1 0", at, flush_cnt[0], cnt[0]);
    end
  endtask

  task automatic test_tx_active();
    int kd, at;
    do_reset();
    act_force[0] = 1'b1;
    for (int k = 0; k < 4; k++) write_byte(0, 8'(8'hC0 + k));
    tick(10);
    tests_run++;
    if (rd_cnt[0] !== 0) begin
      tests_failed++;
      $display("FAIL pop_while_active: got %0d pops, required 0", rd_cnt[0]);
    end
    act_force[0] = 1'b0;
    kd = cyc;
    wait_ev(0, 1, 10, at);
    tests_run++;
    if (at !== kd + 3) begin
      tests_failed++;
      $display("FAIL dv_after_active_drop: got cycle %0d, required %0d", at, kd + 3);
    end
    wait_ev(0, 4, 200, at);
    tests_run++;
    if (at < 0 || dv_cnt[0] !== 4 || done_cnt[0] !== 4) begin
      tests_failed++;
      $display("FAIL dv_per_done: idle_at=%0d dv=%0d done=%0d, required >=0 4 4", at, dv_cnt[0], done_cnt[0]);
    end
  endtask

  task automatic test_count_limits();
    int kd, at;
    do_reset();
    act_force[0] = 1'b1;
    for (int k = 0; k < 5; k++) write_byte(0, 8'(8'h50 + k));
    tests_run++;
    if (cnt[0] !== 5'd5) begin
      tests_failed++;
      $display("FAIL count_five: got %0d, required 5", cnt[0]);
    end
    act_force[0] = 1'b0;
    kd = cyc;
    tick(1);
    wr[0] = 1'b1;
    wdata[0] = 8'h66;
    tick(1);
    wr[0] = 1'b0;
    tests_run++;
    if (last_rd[0] !== kd + 1) begin
      tests_failed++;
      $display("FAIL pop_with_write: pop at cycle %0d, required %0d", last_rd[0], kd + 1);
    end
    tests_run++;
    if (cnt[0] !== 5'd5) begin
      tests_failed++;
      $display("FAIL count_wr_rd_same_cycle: got %0d, required 5", cnt[0]);
    end
    wait_ev(0, 4, 300, at);
    tests_run++;
    if (at < 0 || cnt[0] !== 5'd0) begin
      tests_failed++;
      $display("FAIL drain_six: idle_at=%0d count=%0d, required >=0 0", at, cnt[0]);
    end
    act_force[0] = 1'b1;
    for (int k = 0; k < 16; k++) write_byte(0, 8'(8'h80 + k));
    tests_run++;
    if (cnt[0] !== 5'd16) begin
      tests_failed++;
      $display("FAIL count_full: got %0d, required 16", cnt[0]);
    end
    write_byte(0, 8'hEE);
    tests_run++;
    if (cnt[0] !== 5'd16) begin
      tests_failed++;
      $display("FAIL count_saturate: got %0d, required 16", cnt[0]);
    end
    act_force[0] = 1'b0;
    wait_ev(0, 0, 10, at);
    wait_ev(0, 4, 600, at);
    tests_run++;
    if (at < 0 || cnt[0] !== 5'd0 || expq[0].size() !== 0) begin
      tests_failed++;
      $display("FAIL drain_full: idle_at=%0d count=%0d left=%0d, required >=0 0 0", at, cnt[0], expq[0].size());
    end
  endtask

  task automatic test_reset_mid_burst();
    int at;
    do_reset();
    for (int k = 0; k < 4; k++) write_byte(0, 8'(8'h30 + k));
    wait_ev(0, 1, 10, at);
    tick(2);
    tests_run++;
    if (at < 0 || busy[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL in_wait_done: dv_at=%0d busy=%b, required >=0 1", at, busy[0]);
    end
    rst = 1'b1;
    tick(1);
    tests_run++;
    if ({busy[0], rd[0], dv[0], flush[0]} !== 4'b0000 || cnt[0] !== 5'd0 || txbyte[0] !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_mid_burst: busy/rd/dv/flush=%b count=%0d byte=%h, required 0000 0 00",
               {busy[0], rd[0], dv[0], flush[0]}, cnt[0], txbyte[0]);
    end
    act_force[0] = 1'b1;
    rst = 1'b0;
    tick(1);
    for (int k = 0; k < 4; k++) write_byte(0, 8'(8'h40 + k));
    tick(10);
    tests_run++;
    if (dv_cnt[0] !== 0 || rd_cnt[0] !== 0) begin
      tests_failed++;
      $display("FAIL dv_while_active: dv=%0d rd=%0d, required 0 0", dv_cnt[0], rd_cnt[0]);
    end
    act_force[0] = 1'b0;
    wait_ev(0, 0, 10, at);
    wait_ev(0, 4, 200, at);
    tests_run++;
    if (at < 0 || cnt[0] !== 5'd0 || expq[0].size() !== 0) begin
      tests_failed++;
      $display("FAIL drain_after_reset: idle_at=%0d count=%0d left=%0d, required >=0 0 0", at, cnt[0], expq[0].size());
    end
  endtask

  task automatic test_gap_and_disable();
    int at, m1, m2;
    do_reset();
    for (int k = 0; k < 5; k++) write_byte(1, 8'(8'h90 + k));
    wait_ev(1, 1, 20, at);
    wait_ev(1, 2, 20, m1);
    wait_ev(1, 0, 20, at);
    tests_run++;
    if (m1 < 0 || at !== m1 + 5) begin
      tests_failed++;
      $display("FAIL gap_spacing: pop at cycle %0d, required %0d", at, m1 + 5);
    end
    wait_ev(1, 1, 20, at);
    en[1] = 1'b0;
    wait_ev(1, 2, 20, m2);
    wait_ev(1, 4, 20, at);
    tests_run++;
    if (m2 < 0 || at !== m2 + 5) begin
      tests_failed++;
      $display("FAIL idle_after_disable: idle at cycle %0d, required %0d", at, m2 + 5);
    end
    tests_run++;
    if (cnt[1] !== 5'd3 || dv_cnt[1] !== 2) begin
      tests_failed++;
      $display("FAIL disable_leftover: count=%0d dv=%0d, required 3 2", cnt[1], dv_cnt[1]);
    end
    en[1] = 1'b1;
    tick(150);
    tests_run++;
    if (rd_cnt[1] !== 2) begin
      tests_failed++;
      $display("FAIL timeout_disabled: got %0d pops, required 2", rd_cnt[1]);
    end
    write_byte(1, 8'hAA);
    wait_ev(1, 0, 10, at);
    wait_ev(1, 4, 300, at);
    tests_run++;
    if (at < 0 || cnt[1] !== 5'd0 || dv_cnt[1] !== 6 || expq[1].size() !== 0) begin
      tests_failed++;
      $display("FAIL resume_drain: idle_at=%0d count=%0d dv=%0d left=%0d, required >=0 0 6 0",
               at, cnt[1], dv_cnt[1], expq[1].size());
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      en[i] = 1'b0;
      wr[i] = 1'b0;
      wdata[i] = 8'h00;
      act_force[i] = 1'b0;
    end
    test_reset();
    test_threshold_burst();
    test_timeout_flush();
    test_tx_active();
    test_count_limits();
    test_reset_mid_burst();
    test_gap_and_disable();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

endmodule
